// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock; result valid WIDTH edges after accept, held until out_ready.
// `define SERIAL_SUB_OVF_EN adds the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_bo;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Full-subtractor cell on the current LSBs.
  assign w_a  = r_a[0];
  assign w_b  = r_b[0];
  assign w_d  = w_a ^ w_b ^ r_borrow;
  assign w_bo = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);

  // r_sh accumulates the running result so diff only changes when a new result lands.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= minuend;
      r_b      <= subtrahend;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == CALC) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_sh     <= {w_d, r_sh[WIDTH-1:1]};
      r_borrow <= w_bo;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= {w_d, r_sh[WIDTH-1:1]};
        r_bout <= w_bo;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // On the last bit, w_a/w_b are the original operand MSBs and w_d is the result MSB.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (w_a ^ w_b) & (w_a ^ w_d);
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors, backpressure, reset abort, random ops.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         sys_clk;
  logic         sys_rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] minuend;
  logic [W-1:0] subtrahend;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_chk;
  int n_err;

  serial_subtractor #(.WIDTH(W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .bout       (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: signed overflow from plain integer arithmetic.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sa - sb;
    return (r > 127) || (r < -128);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output logic bo, output logic ov, output int lat);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge sys_clk); #1;
      t++;
    end
    check("op_in_ready", {63'd0, in_ready}, 64'd1);
    minuend    = a;
    subtrahend = b;
    in_valid   = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    d  = diff;
    bo = bout;
    ov = get_ovf();
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t         vecs[8];
  logic [W-1:0] r_d;
  logic         r_bo;
  logic         r_ov;
  int           lat;

  initial begin
    n_chk      = 0;
    n_err      = 0;
    sys_rst    = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    minuend    = '0;
    subtrahend = '0;

    vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h00, d: 8'h00, bo: 1'b0, ov: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h10, b: 8'h01, d: 8'h0F, bo: 1'b0, ov: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1};
    vecs[6] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1};
    vecs[7] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1, ov: 1'b0};

    // Reset state
    #12;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_diff",      {56'd0, diff},      64'd0);
    check("rst_bout",      {63'd0, bout},      64'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, r_d, r_bo, r_ov, lat);
      check($sformatf("vec%0d_diff", i), {56'd0, r_d}, {56'd0, vecs[i].d});
      check($sformatf("vec%0d_bout", i), {63'd0, r_bo}, {63'd0, vecs[i].bo});
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(W));
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("vec%0d_ovf", i), {63'd0, r_ov}, {63'd0, vecs[i].ov});
`endif
      check($sformatf("vec%0d_release", i), {63'd0, out_valid}, 64'd0);
    end

    // Backpressure: hold result 10 cycles while new requests are offered
    minuend = 8'hA5; subtrahend = 8'h5A; in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    for (int c = 0; c < 10; c++) begin
      in_valid   = c[0];
      minuend    = 8'($urandom);
      subtrahend = 8'($urandom);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_diff",      {56'd0, diff},      64'h4B);
      check("bp_bout",      {63'd0, bout},      64'd0);
      check("bp_in_ready",  {63'd0, in_ready},  64'd0);
      @(posedge sys_clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    out_ready = 1'b0;
    repeat (W + 2) @(posedge sys_clk);
    #1;
    check("bp_no_ghost_op", {63'd0, out_valid}, 64'd0);
    check("bp_idle_ready",  {63'd0, in_ready},  64'd1);

    // Reset mid-calculation after 4 bits
    minuend = 8'hFF; subtrahend = 8'h01; in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    check("arst_in_ready",  {63'd0, in_ready},  64'd1);
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_diff",      {56'd0, diff},      64'd0);
    check("arst_bout",      {63'd0, bout},      64'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    repeat (W + 2) @(posedge sys_clk);
    #1;
    check("arst_discarded", {63'd0, out_valid}, 64'd0);
    run_op(8'h10, 8'h01, r_d, r_bo, r_ov, lat);
    check("arst_next_diff", {56'd0, r_d},  64'h0F);
    check("arst_next_bout", {63'd0, r_bo}, 64'd0);
    check("arst_next_lat",  64'(lat),      64'(W));

    // Random ops with random handshakes against an arithmetic model
    begin
      logic [W:0]   exp_q[$];
      logic         exp_ov_q[$];
      logic [W:0]   exp_v;
      logic         exp_ov;
      logic         acc;
      logic         take;
      logic [W-1:0] d_s;
      logic         bo_s;
      logic         ov_s;
      int           done_ops;
      int           cyc;
      done_ops = 0;
      cyc      = 0;
      while (done_ops < 1000 && cyc < 40000) begin
        in_valid   = ($urandom_range(0, 2) != 0);
        minuend    = 8'($urandom);
        subtrahend = 8'($urandom);
        out_ready  = ($urandom_range(0, 3) != 0);
        acc  = in_valid && in_ready;
        take = out_valid && out_ready;
        d_s  = diff;
        bo_s = bout;
        ov_s = get_ovf();
        if (acc) begin
          exp_q.push_back({1'b0, minuend} - {1'b0, subtrahend});
          exp_ov_q.push_back(ref_ovf(minuend, subtrahend));
        end
        @(posedge sys_clk); #1;
        cyc++;
        if (take) begin
          if (exp_q.size() == 0) begin
            check("rnd_unexpected_result", {63'd0, take}, 64'd0);
          end else begin
            exp_v  = exp_q.pop_front();
            exp_ov = exp_ov_q.pop_front();
            check("rnd_result", {55'd0, bo_s, d_s}, {55'd0, exp_v});
`ifdef SERIAL_SUB_OVF_EN
            check("rnd_ovf", {63'd0, ov_s}, {63'd0, exp_ov});
`endif
          end
          done_ops++;
        end
      end
      check("rnd_ops_completed", 64'(done_ops), 64'd1000);
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
